// File: rtl/xadac_axi_mem.sv
// xadac_axi_mem: single-beat AXI slave scratchpad with independent read and write FSMs.
module xadac_axi_mem #(
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 128,
  parameter int Depth     = 256
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [IdWidth-1:0]     aw_id,
  input  logic [AddrWidth-1:0]   aw_addr,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [DataWidth-1:0]   w_data,
  input  logic [DataWidth/8-1:0] w_strb,
  input  logic                   w_valid,
  output logic                   w_ready,
  output logic [IdWidth-1:0]     b_id,
  output logic [1:0]             b_resp,
  output logic                   b_valid,
  input  logic                   b_ready,
  input  logic [IdWidth-1:0]     ar_id,
  input  logic [AddrWidth-1:0]   ar_addr,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  output logic [IdWidth-1:0]     r_id,
  output logic [DataWidth-1:0]   r_data,
  output logic [1:0]             r_resp,
  output logic                   r_valid,
  input  logic                   r_ready
);
  localparam int StrbW = DataWidth / 8;
  localparam int OffW  = $clog2(StrbW);
  localparam int IdxW  = $clog2(Depth);
  localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(Depth * StrbW);

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} r_state_e;

  logic [DataWidth-1:0] mem [Depth];
  w_state_e             w_state;
  r_state_e             r_state;
  logic [IdWidth-1:0]   aw_id_q, ar_id_q;
  logic [AddrWidth-1:0] aw_addr_q, ar_addr_q;
  logic [DataWidth-1:0] w_data_q;
  logic [StrbW-1:0]     w_strb_q;
  logic                 aw_hs, w_hs, commit, wr_in_range, rd_in_range;
  logic [IdWidth-1:0]   wr_id;
  logic [AddrWidth-1:0] wr_addr;
  logic [DataWidth-1:0] wr_data;
  logic [StrbW-1:0]     wr_strb;
  logic [IdxW-1:0]      wr_idx, rd_idx;

  // Readies decode state only; rstn gating keeps them low during reset cycles.
  assign aw_ready = rstn && (w_state == W_IDLE || w_state == W_WAIT_AW);
  assign w_ready  = rstn && (w_state == W_IDLE || w_state == W_WAIT_W);
  assign ar_ready = rstn && r_state == R_IDLE;

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;
  // Commit when the second half of the AW/W pair arrives (or both together).
  assign commit = (aw_hs || w_state == W_WAIT_W) && (w_hs || w_state == W_WAIT_AW);

  assign wr_id       = aw_hs ? aw_id : aw_id_q;
  assign wr_addr     = aw_hs ? aw_addr : aw_addr_q;
  assign wr_data     = w_hs ? w_data : w_data_q;
  assign wr_strb     = w_hs ? w_strb : w_strb_q;
  assign wr_in_range = wr_addr < MemBytes;
  assign wr_idx      = wr_addr[OffW +: IdxW];
  assign rd_in_range = ar_addr_q < MemBytes;
  assign rd_idx      = ar_addr_q[OffW +: IdxW];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      b_valid <= 1'b0;
      b_id    <= '0;
      b_resp  <= 2'b00;
    end else begin
      if (aw_hs) begin
        aw_id_q   <= aw_id;
        aw_addr_q <= aw_addr;
      end
      if (w_hs) begin
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      if (commit) begin
        w_state <= W_RESP;
        b_valid <= 1'b1;
        b_id    <= wr_id;
        b_resp  <= wr_in_range ? 2'b00 : 2'b10;
      end else if (w_state == W_RESP && b_ready) begin
        w_state <= W_IDLE;
        b_valid <= 1'b0;
      end else if (w_state == W_IDLE && aw_hs) begin
        w_state <= W_WAIT_W;
      end else if (w_state == W_IDLE && w_hs) begin
        w_state <= W_WAIT_AW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_in_range)
      for (int i = 0; i < StrbW; i++)
        if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
  end

  // The word is sampled with a non-blocking read, so a same-edge commit is not visible.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
      r_resp  <= 2'b00;
    end else if (r_state == R_IDLE && ar_valid && ar_ready) begin
      ar_id_q   <= ar_id;
      ar_addr_q <= ar_addr;
      r_state   <= R_ACCESS;
    end else if (r_state == R_ACCESS) begin
      r_state <= R_RESP;
      r_valid <= 1'b1;
      r_id    <= ar_id_q;
      r_data  <= rd_in_range ? mem[rd_idx] : '0;
      r_resp  <= rd_in_range ? 2'b00 : 2'b10;
    end else if (r_state == R_RESP && r_ready) begin
      r_state <= R_IDLE;
      r_valid <= 1'b0;
    end
  end
endmodule
